// File: rtl/mem_arbiter.sv
// Request/grant sequencer sharing one word memory between the fetch and load/store ports,
// with read-modify-write merging for partial stores. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [3:0]  ls_be,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

   state_t      state_q, state_d;
   logic        id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        if_rvalid_q, if_rvalid_d;
   logic        ls_rvalid_q, ls_rvalid_d;
   logic [31:0] merged;
   logic        window;
   logic        prio_sel;
   logic        addr_lsb_unused;

   assign addr_lsb_unused = ^{if_addr[1:0], ls_addr[1:0]};

`ifdef MEM_ARB_RR_EN
   logic prio_q, prio_d;

   // The pointer moves to the requester that did not just win.
   always_comb begin
      prio_d = prio_q;
      if (if_gnt || ls_gnt) begin
         prio_d = ls_gnt;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prio_q <= RESET_PRIO;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign prio_sel = prio_q;
`else
   assign prio_sel = RESET_PRIO;
`endif

   // prio_sel = 1 favours fetch when both requesters are pending.
   assign window = (state_q == IDLE) || (state_q == RESP);
   assign if_gnt = window && if_req && (!ls_req || prio_sel);
   assign ls_gnt = window && ls_req && (!if_req || !prio_sel);

   assign mem_a     = addr_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      mem_we      = 1'b0;
      mem_wd      = 32'h0;
      merged      = mem_rd;

      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rd[8*i +: 8];
      end

      case (state_q)
         IDLE, RESP: begin
            if (if_gnt || ls_gnt) begin
               state_d = SERVE;
               id_d    = if_gnt;
               addr_d  = if_gnt ? {if_addr[31:2], 2'b00} : {ls_addr[31:2], 2'b00};
               we_d    = ls_gnt && ls_we;
               be_d    = ls_gnt ? ls_be : 4'h0;
               wdata_d = ls_gnt ? ls_wdata : 32'h0;
            end else begin
               state_d = IDLE;
            end
         end
         SERVE: begin
            state_d = RESP;
            if (we_q) begin
               mem_wd = merged;
               mem_we = |be_q;
            end
            // For stores the response carries the word as it was before the write.
            if (id_q) begin
               if_rdata_d  = mem_rd;
               if_rvalid_d = 1'b1;
            end else begin
               ls_rdata_d  = mem_rd;
               ls_rvalid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         id_q        <= 1'b0;
         addr_q      <= 32'h0;
         we_q        <= 1'b0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
         if_rdata_q  <= 32'h0;
         ls_rdata_q  <= 32'h0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset and contention sequences.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [3:0]  ls_be;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we;
   logic [31:0] if_rdata, ls_rdata, mem_a, mem_wd, mem_rd;
   logic [31:0] mem [64];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        ls_req;
      logic        ls_we;
      logic [3:0]  ls_be;
      logic [31:0] ls_addr;
      logic [31:0] ls_wdata;
      logic        e_if_gnt;
      logic        e_ls_gnt;
      logic        e_if_rvalid;
      logic        e_ls_rvalid;
      logic        e_mem_we;
      logic [31:0] e_mem_a;
      logic [31:0] e_mem_wd;
      logic [31:0] e_if_rdata;
      logic [31:0] e_ls_rdata;
   } vec_t;

   vec_t vecs[15];

   always #5 CLK = ~CLK;

   assign mem_rd = mem[mem_a[7:2]];

   always @(posedge CLK) begin
      if (mem_we) mem[mem_a[7:2]] <= mem_wd;
   end

   mem_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      if_req   = v.if_req;
      if_addr  = v.if_addr;
      ls_req   = v.ls_req;
      ls_we    = v.ls_we;
      ls_be    = v.ls_be;
      ls_addr  = v.ls_addr;
      ls_wdata = v.ls_wdata;
   endtask

   task automatic clearInputs();
      if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
      ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
   endtask

   task automatic doReset();
      RST_N = 1'b0;
      clearInputs();
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " if_gnt"}, {31'h0, if_gnt}, 32'h0);
      checkOutput({tag, " ls_gnt"}, {31'h0, ls_gnt}, 32'h0);
      checkOutput({tag, " if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
      checkOutput({tag, " ls_rvalid"}, {31'h0, ls_rvalid}, 32'h0);
      checkOutput({tag, " mem_we"}, {31'h0, mem_we}, 32'h0);
      checkOutput({tag, " mem_a"}, mem_a, 32'h0);
      checkOutput({tag, " mem_wd"}, mem_wd, 32'h0);
      checkOutput({tag, " if_rdata"}, if_rdata, 32'h0);
      checkOutput({tag, " ls_rdata"}, ls_rdata, 32'h0);
   endtask

   initial begin
      int gidx;
      int ls_cnt;
      int if_cnt;
      logic exp_ls_win [4];

      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4]  = 32'hDEADBEEF;
      mem[8]  = 32'h11223344;
      mem[12] = 32'hCAFEF00D;

      //         ifr  if_addr     lsr  we    be    ls_addr     ls_wdata      ig  lg  iv  lv  we   mem_a       mem_wd        if_rdata      ls_rdata
      vecs[0]  = '{1'b1, 32'h12, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,  32'h0,        32'h0,        32'h0};
      vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0, 32'h10, 32'h0,        32'h0,        32'h0};
      vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
      vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 4'h4, 32'h21, 32'h00AA0000, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
      vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b1, 32'h20, 32'h11AA3344, 32'hDEADBEEF, 32'h0};
      vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h20, 32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 32'h11223344};
      vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 32'h11223344};
      vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 32'h11AA3344};
      vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 32'h11AA3344};
      vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0, 32'h30, 32'hCAFEF00D, 32'hDEADBEEF, 32'h11AA3344};
      vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h30, 32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0, 32'h30, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
      vecs[11] = '{1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0, 32'h30, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
      vecs[12] = '{1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1,1'b0,1'b0,1'b1,1'b0, 32'h30, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
      vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
      vecs[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0, 32'h20, 32'h0,        32'h11AA3344, 32'hCAFEF00D};

      RST_N = 1'b0;
      clearInputs();
      repeat (2) @(posedge CLK);
      #2 checkAllZero("reset");
      RST_N = 1'b1;

      foreach (vecs[i]) begin
         @(posedge CLK);
         #1 applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d if_gnt", i), {31'h0, if_gnt}, {31'h0, vecs[i].e_if_gnt});
         checkOutput($sformatf("v%0d ls_gnt", i), {31'h0, ls_gnt}, {31'h0, vecs[i].e_ls_gnt});
         checkOutput($sformatf("v%0d if_rvalid", i), {31'h0, if_rvalid}, {31'h0, vecs[i].e_if_rvalid});
         checkOutput($sformatf("v%0d ls_rvalid", i), {31'h0, ls_rvalid}, {31'h0, vecs[i].e_ls_rvalid});
         checkOutput($sformatf("v%0d mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].e_mem_we});
         checkOutput($sformatf("v%0d mem_a", i), mem_a, vecs[i].e_mem_a);
         checkOutput($sformatf("v%0d mem_wd", i), mem_wd, vecs[i].e_mem_wd);
         checkOutput($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
         checkOutput($sformatf("v%0d ls_rdata", i), ls_rdata, vecs[i].e_ls_rdata);
      end
      checkOutput("be0 memory unchanged", mem[12], 32'hCAFEF00D);
      checkOutput("byte store committed", mem[8], 32'h11AA3344);

      // Reset asserted during the SERVE cycle of a full-word store.
      @(posedge CLK);
      #1 clearInputs();
      doReset();
      @(posedge CLK);
      #1 ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h10; ls_wdata = 32'h12345678;
      #1 checkOutput("rst store gnt", {31'h0, ls_gnt}, 32'h1);
      @(posedge CLK);
      #1 clearInputs();
      #1 checkOutput("rst serve mem_we", {31'h0, mem_we}, 32'h1);
      checkOutput("rst serve mem_wd", mem_wd, 32'h12345678);
      RST_N = 1'b0;
      #1 checkAllZero("mid-serve reset");
      @(posedge CLK);
      #1 checkOutput("rst no write", mem[4], 32'hDEADBEEF);
      RST_N = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK);
         #2 checkOutput($sformatf("rst no rvalid c%0d", c), {30'h0, if_rvalid, ls_rvalid}, 32'h0);
      end
      @(posedge CLK);
      #1 if_req = 1'b1; if_addr = 32'h13;
      #1 checkOutput("post-rst if_gnt", {31'h0, if_gnt}, 32'h1);
      @(posedge CLK);
      #1 if_req = 1'b0;
      @(posedge CLK);
      #2 checkOutput("post-rst if_rvalid", {31'h0, if_rvalid}, 32'h1);
      checkOutput("post-rst if_rdata", if_rdata, 32'hDEADBEEF);

      // Both requesters held for 8 cycles, then released so the last access drains.
`ifdef MEM_ARB_RR_EN
      exp_ls_win = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_ls_win = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      @(posedge CLK);
      #1 doReset();
      gidx = 0;
      ls_cnt = 0;
      if_cnt = 0;
      for (int c = 0; c < 11; c++) begin
         @(posedge CLK);
         #1 if_req = (c < 8); ls_req = (c < 8); ls_we = 1'b0;
         ls_addr = 32'h30; if_addr = 32'h10;
         #1;
         if (c < 8 && c % 2 == 0) begin
            checkOutput($sformatf("cont c%0d ls_gnt", c), {31'h0, ls_gnt}, {31'h0, exp_ls_win[gidx]});
            checkOutput($sformatf("cont c%0d if_gnt", c), {31'h0, if_gnt}, {31'h0, !exp_ls_win[gidx]});
            gidx++;
         end else begin
            checkOutput($sformatf("cont c%0d no gnt", c), {30'h0, if_gnt, ls_gnt}, 32'h0);
         end
         if (c >= 2 && c <= 8 && c % 2 == 0) begin
            checkOutput($sformatf("cont c%0d ls_rvalid", c), {31'h0, ls_rvalid}, {31'h0, exp_ls_win[c/2-1]});
            checkOutput($sformatf("cont c%0d if_rvalid", c), {31'h0, if_rvalid}, {31'h0, !exp_ls_win[c/2-1]});
            if (exp_ls_win[c/2-1]) checkOutput($sformatf("cont c%0d ls_rdata", c), ls_rdata, 32'hCAFEF00D);
            else                   checkOutput($sformatf("cont c%0d if_rdata", c), if_rdata, 32'hDEADBEEF);
         end else begin
            checkOutput($sformatf("cont c%0d no rvalid", c), {30'h0, if_rvalid, ls_rvalid}, 32'h0);
         end
         if (ls_rvalid) ls_cnt++;
         if (if_rvalid) if_cnt++;
      end
`ifdef MEM_ARB_RR_EN
      checkOutput("cont ls completions", ls_cnt, 32'd2);
      checkOutput("cont if completions", if_cnt, 32'd2);
`else
      checkOutput("cont ls completions", ls_cnt, 32'd4);
      checkOutput("cont if completions", if_cnt, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
